// File: rtl/imm_extend_pipe_if.sv
// Valid/ready handshake bundle for the immediate-extension unit.
// The upstream side drives in_*; the downstream side drives out_ready.
interface imm_extend_pipe_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_trunc;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_trunc
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_trunc
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (zero/sign/upper/branch-offset) with a registered
// output stage, one-entry skid buffer and a saturating truncation-event counter.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_extend_pipe_if.slave bus,
  output logic [CNT_W-1:0] trunc_cnt
);
  localparam int unsigned UP_SH = OUT_W - IN_W;

  logic signed [IN_W-1:0] w_in_s;
  logic [OUT_W-1:0]       w_ext;
  logic [OUT_W-1:0]       w_res;
  logic                   w_trunc;
  logic                   w_in_fire;
  logic                   w_out_fire;

  logic                   r_out_valid;
  logic [OUT_W-1:0]       r_out_data;
  logic                   r_out_trunc;
  logic                   r_skid_valid;
  logic [OUT_W-1:0]       r_skid_data;
  logic                   r_skid_trunc;
  logic [CNT_W-1:0]       r_cnt;

  // Extension datapath; the branch-offset mode flags loss of the top significant bits.
  always_comb begin
    w_in_s  = bus.in_data;
    w_ext   = OUT_W'(w_in_s);
    w_res   = '0;
    w_trunc = 1'b0;
    unique case (bus.in_mode)
      2'b00: w_res = OUT_W'(bus.in_data);
      2'b01: w_res = w_ext;
      2'b10: w_res = OUT_W'(bus.in_data) << UP_SH;
      2'b11: begin
        w_res   = w_ext << 2;
        w_trunc = (w_ext[OUT_W-1 -: 3] != 3'b000) && (w_ext[OUT_W-1 -: 3] != 3'b111);
      end
      default: w_res = '0;
    endcase
  end

  assign w_in_fire  = bus.in_valid & ~r_skid_valid;
  assign w_out_fire = r_out_valid & bus.out_ready;

  // Output register + skid entry; the skid only fills when the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_trunc  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_trunc <= 1'b0;
    end else if (r_skid_valid) begin
      if (w_out_fire) begin
        r_out_data   <= r_skid_data;
        r_out_trunc  <= r_skid_trunc;
        r_skid_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      if (!r_out_valid || w_out_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
        r_out_trunc <= w_trunc;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_res;
        r_skid_trunc <= w_trunc;
      end
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  // Counts truncating results at acceptance time, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_in_fire && w_trunc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = ~r_skid_valid;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_trunc = r_out_trunc;
  assign trunc_cnt     = r_cnt;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: two instances (16->32 with 8-bit counter, 16->16 with 2-bit
// counter), table-driven vectors and a queue scoreboard fed at acceptance.
module tb_imm_extend_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) ifa ();
  imm_extend_pipe_if #(.IN_W(16), .OUT_W(16)) ifb ();
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .trunc_cnt(cnt_a));
  imm_extend_pipe #(.IN_W(16), .OUT_W(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .trunc_cnt(cnt_b));

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    logic [31:0] exp_d;
    logic        exp_t;
    logic [7:0]  exp_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        t;
    int          cyc;
    bit          lat;
  } sb_t;

  sb_t qa[$];
  sb_t qb[$];
  logic [31:0] a_exp_d, b_exp_d;
  logic        a_exp_t, b_exp_t;
  bit          a_exp_lat, b_exp_lat;

  vec_t ta[9];
  vec_t tb[9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", nm, got, exp);
    end
  endtask

  // Scoreboard: compare on output fire, push on input fire (both about to happen at next posedge).
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.out_valid && ifa.out_ready) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected: got=0x%08h expected=none", ifa.out_data);
        end else begin
          sb_t e;
          e = qa.pop_front();
          chk("a_data", ifa.out_data, e.d);
          chk("a_trunc", 32'(ifa.out_trunc), 32'(e.t));
          if (e.lat) chk("a_latency", 32'(cyc), 32'(e.cyc + 1));
        end
      end
      if (ifa.in_valid && ifa.in_ready) qa.push_back('{a_exp_d, a_exp_t, cyc, a_exp_lat});
      if (ifb.out_valid && ifb.out_ready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got=0x%04h expected=none", ifb.out_data);
        end else begin
          sb_t e;
          e = qb.pop_front();
          chk("b_data", 32'(ifb.out_data), e.d);
          chk("b_trunc", 32'(ifb.out_trunc), 32'(e.t));
          if (e.lat) chk("b_latency", 32'(cyc), 32'(e.cyc + 1));
        end
      end
      if (ifb.in_valid && ifb.in_ready) qb.push_back('{b_exp_d, b_exp_t, cyc, b_exp_lat});
    end
  end

  task automatic send_a(input logic [15:0] d, input logic [1:0] m,
                        input logic [31:0] ed, input logic et, input bit lat);
    int n;
    n = 0;
    ifa.in_valid = 1'b1; ifa.in_data = d; ifa.in_mode = m;
    a_exp_d = ed; a_exp_t = et; a_exp_lat = lat;
    while (!ifa.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!ifa.in_ready) begin
      checks++; errors++;
      $display("FAIL send_a_timeout: got=in_ready 0 expected=1 within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_b(input logic [15:0] d, input logic [1:0] m,
                        input logic [31:0] ed, input logic et, input bit lat);
    int n;
    n = 0;
    ifb.in_valid = 1'b1; ifb.in_data = d; ifb.in_mode = m;
    b_exp_d = ed; b_exp_t = et; b_exp_lat = lat;
    while (!ifb.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!ifb.in_ready) begin
      checks++; errors++;
      $display("FAIL send_b_timeout: got=in_ready 0 expected=1 within 50 cycles");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=no finish expected=finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ta[0] = '{2'b00, 16'h8001, 32'h0000_8001, 1'b0, 8'd0};
    ta[1] = '{2'b01, 16'h8001, 32'hFFFF_8001, 1'b0, 8'd0};
    ta[2] = '{2'b10, 16'h8001, 32'h8001_0000, 1'b0, 8'd0};
    ta[3] = '{2'b11, 16'h8001, 32'hFFFE_0004, 1'b0, 8'd0};
    ta[4] = '{2'b01, 16'h7FFF, 32'h0000_7FFF, 1'b0, 8'd0};
    ta[5] = '{2'b11, 16'h7FFF, 32'h0001_FFFC, 1'b0, 8'd0};
    ta[6] = '{2'b00, 16'hFFFF, 32'h0000_FFFF, 1'b0, 8'd0};
    ta[7] = '{2'b10, 16'h1234, 32'h1234_0000, 1'b0, 8'd0};
    ta[8] = '{2'b11, 16'hC000, 32'hFFFF_0000, 1'b0, 8'd0};

    tb[0] = '{2'b00, 16'h8001, 32'h0000_8001, 1'b0, 8'd0};
    tb[1] = '{2'b01, 16'h8001, 32'h0000_8001, 1'b0, 8'd0};
    tb[2] = '{2'b10, 16'h8001, 32'h0000_8001, 1'b0, 8'd0};
    tb[3] = '{2'b11, 16'h4000, 32'h0000_0000, 1'b1, 8'd1};
    tb[4] = '{2'b11, 16'hE000, 32'h0000_8000, 1'b0, 8'd1};
    tb[5] = '{2'b11, 16'h2000, 32'h0000_8000, 1'b1, 8'd2};
    tb[6] = '{2'b11, 16'h8000, 32'h0000_0000, 1'b1, 8'd3};
    tb[7] = '{2'b11, 16'hBFFF, 32'h0000_FFFC, 1'b1, 8'd3};
    tb[8] = '{2'b11, 16'h4000, 32'h0000_0000, 1'b1, 8'd3};

    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_mode = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_mode = '0; ifb.out_ready = 1'b1;
    a_exp_d = '0; a_exp_t = 1'b0; a_exp_lat = 1'b0;
    b_exp_d = '0; b_exp_t = 1'b0; b_exp_lat = 1'b0;

    // Power-on reset
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_out_data", ifa.out_data, 32'd0);
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode table on the 16->32 instance, back-to-back with out_ready=1
    for (int i = 0; i < 9; i++) begin
      send_a(ta[i].data, ta[i].mode, ta[i].exp_d, ta[i].exp_t, 1'b1);
      chk("a_in_ready_stream", 32'(ifa.in_ready), 32'd1);
      chk("a_cnt", 32'(cnt_a), 32'(ta[i].exp_cnt));
    end
    ifa.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("a_drain_table", 32'(qa.size()), 32'd0);

    // Backpressure: A and B accepted, C stalls until the output drains
    ifa.out_ready = 1'b0;
    send_a(16'h0011, 2'b00, 32'h0000_0011, 1'b0, 1'b0);
    send_a(16'h0022, 2'b00, 32'h0000_0022, 1'b0, 1'b0);
    ifa.in_valid = 1'b1; ifa.in_data = 16'h0033; ifa.in_mode = 2'b00;
    a_exp_d = 32'h0000_0033; a_exp_t = 1'b0; a_exp_lat = 1'b1;
    chk("bp_in_ready_low", 32'(ifa.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_in_ready_held", 32'(ifa.in_ready), 32'd0);
    chk("bp_out_valid", 32'(ifa.out_valid), 32'd1);
    chk("bp_hold_data", ifa.out_data, 32'h0000_0011);
    ifa.out_ready = 1'b1;
    send_a(16'h0033, 2'b00, 32'h0000_0033, 1'b0, 1'b1);
    ifa.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("a_drain_bp", 32'(qa.size()), 32'd0);

    // Truncation and counter saturation on the 16->16 instance
    for (int i = 0; i < 9; i++) begin
      send_b(tb[i].data, tb[i].mode, tb[i].exp_d, tb[i].exp_t, 1'b1);
      chk("b_cnt", 32'(cnt_b), 32'(tb[i].exp_cnt));
    end
    ifb.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("b_drain", 32'(qb.size()), 32'd0);

    // Reset mid-stream with both skids full
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
    send_a(16'h0101, 2'b00, 32'h0000_0101, 1'b0, 1'b0);
    send_a(16'h0202, 2'b00, 32'h0000_0202, 1'b0, 1'b0);
    ifa.in_valid = 1'b0;
    send_b(16'h0101, 2'b00, 32'h0000_0101, 1'b0, 1'b0);
    send_b(16'h0202, 2'b00, 32'h0000_0202, 1'b0, 1'b0);
    ifb.in_valid = 1'b0;
    chk("pre_rst_a_ready", 32'(ifa.in_ready), 32'd0);
    chk("pre_rst_b_ready", 32'(ifb.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_valid", 32'(ifa.out_valid), 32'd0);
    chk("mid_rst_a_data", ifa.out_data, 32'd0);
    chk("mid_rst_a_trunc", 32'(ifa.out_trunc), 32'd0);
    chk("mid_rst_a_ready", 32'(ifa.in_ready), 32'd1);
    chk("mid_rst_b_valid", 32'(ifb.out_valid), 32'd0);
    chk("mid_rst_b_ready", 32'(ifb.in_ready), 32'd1);
    chk("mid_rst_b_cnt", 32'(cnt_b), 32'd0);
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    @(posedge clk); #1;

    // Flow resumes after reset with nothing stale left behind
    send_a(16'h8001, 2'b01, 32'hFFFF_8001, 1'b0, 1'b1);
    ifa.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("a_drain_post_rst", 32'(qa.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
